// File: rtl/ram_port_arbiter.sv
// Two-port front end for a single-port ram with a registered read address and 1-cycle latency.
// Round-robin arbitration with a bounded burst, so that neither requester starves.
module ram_port_arbiter #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 10,
    parameter int unsigned BURST = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] din_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int unsigned CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] BurstMax = CW'(BURST);

    typedef enum logic [1:0] {OwnNone, OwnA, OwnB} owner_e;

    owner_e        owner_q, owner_d;
    logic          last_q, last_d;  // 0: A was served last, 1: B was served last
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rvalid_a_q, rvalid_a_d;
    logic          rvalid_b_q, rvalid_b_d;
    logic          pick_a, pick_b;

    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        unique case (owner_q)
            OwnA: begin
                if (req_a && ((cnt_q < BurstMax) || !req_b)) pick_a = 1'b1;
                else if (req_b)                               pick_b = 1'b1;
            end
            OwnB: begin
                if (req_b && ((cnt_q < BurstMax) || !req_a)) pick_b = 1'b1;
                else if (req_a)                               pick_a = 1'b1;
            end
            default: begin
                if (req_a && req_b) begin
                    pick_a = last_q;
                    pick_b = ~last_q;
                end else begin
                    pick_a = req_a;
                    pick_b = req_b;
                end
            end
        endcase
    end

    // Grants are suppressed while reset is asserted, independent of the registered state.
    assign gnt_a = pick_a & rstn;
    assign gnt_b = pick_b & rstn;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr_a;
        ram_din  = din_a;
        if (gnt_b) begin
            ram_we   = we_b;
            ram_addr = addr_b;
            ram_din  = din_b;
        end else if (gnt_a) begin
            ram_we = we_a;
        end
    end

    always_comb begin
        owner_d    = OwnNone;
        last_d     = last_q;
        cnt_d      = '0;
        rvalid_a_d = gnt_a & ~we_a;
        rvalid_b_d = gnt_b & ~we_b;
        if (gnt_a) begin
            owner_d = OwnA;
            last_d  = 1'b0;
            if (owner_q == OwnA) cnt_d = (cnt_q == BurstMax) ? cnt_q : cnt_q + CW'(1);
            else                 cnt_d = CW'(1);
        end else if (gnt_b) begin
            owner_d = OwnB;
            last_d  = 1'b1;
            if (owner_q == OwnB) cnt_d = (cnt_q == BurstMax) ? cnt_q : cnt_q + CW'(1);
            else                 cnt_d = CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_q    <= OwnNone;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = ram_dout;
    assign rdata_b  = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: grants checked as issued, read data checked
// by a negedge monitor against per-port expected-data queues.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req_a, we_a, req_b, we_b;
    logic [9:0] addr_a, addr_b;
    logic [7:0] din_a, din_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic [7:0] ram_din, ram_dout;

    logic [7:0] mem [0:1023];
    logic [9:0] ram_addr_q;

    int checks = 0;
    int errors = 0;
    logic [7:0] qa [$];
    logic [7:0] qb [$];

    ram_port_arbiter #(.DW(8), .AW(10), .BURST(4)) dut (
        .clk(clk), .rstn(rstn),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port ram model: write at posedge, registered read address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] = ram_din;
        ram_addr_q = ram_addr;
    end
    assign ram_dout = mem[ram_addr_q];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid_a) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL rvalid_a unexpected: got rdata %0h expected no rvalid", rdata_a);
            end else begin
                logic [7:0] e;
                e = qa.pop_front();
                if (rdata_a !== e) begin
                    errors++;
                    $display("FAIL rdata_a: got %0h expected %0h at %0t", rdata_a, e, $time);
                end
            end
        end
        if (rvalid_b) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL rvalid_b unexpected: got rdata %0h expected no rvalid", rdata_b);
            end else begin
                logic [7:0] e;
                e = qb.pop_front();
                if (rdata_b !== e) begin
                    errors++;
                    $display("FAIL rdata_b: got %0h expected %0h at %0t", rdata_b, e, $time);
                end
            end
        end
    end

    // One cycle: drive both ports, check the grant and ram side, queue expected read data.
    task automatic step(input logic ra, input logic wa, input logic [9:0] aa, input logic [7:0] da,
                        input logic rb, input logic wb, input logic [9:0] ab, input logic [7:0] db,
                        input logic ega, input logic egb, input logic [7:0] ed, input bit push);
        req_a = ra; we_a = wa; addr_a = aa; din_a = da;
        req_b = rb; we_b = wb; addr_b = ab; din_b = db;
        #1;
        chk("gnt_a", 32'(gnt_a), 32'(ega));
        chk("gnt_b", 32'(gnt_b), 32'(egb));
        chk("ram_we", 32'(ram_we), ega ? 32'(wa) : (egb ? 32'(wb) : 32'd0));
        if (ega || egb) chk("ram_addr", 32'(ram_addr), ega ? 32'(aa) : 32'(ab));
        if ((ega && wa) || (egb && wb)) chk("ram_din", 32'(ram_din), ega ? 32'(da) : 32'(db));
        if (push && ega && !wa) qa.push_back(ed);
        if (push && egb && !wb) qb.push_back(ed);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 10'd0, 8'd0, 0, 0, 10'd0, 8'd0, 0, 0, 8'd0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[5] = 8'h3C;
        rstn = 1'b0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'd3; din_a = 8'hFF;
        req_b = 1'b1; we_b = 1'b1; addr_b = 10'd4; din_b = 8'hEE;
        #2;
        chk("reset gnt_a", 32'(gnt_a), 32'd0);
        chk("reset gnt_b", 32'(gnt_b), 32'd0);
        chk("reset ram_we", 32'(ram_we), 32'd0);
        chk("reset rvalid_a", 32'(rvalid_a), 32'd0);
        chk("reset rvalid_b", 32'(rvalid_b), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Single A read of preloaded data.
        step(1, 0, 10'd5, 8'd0, 0, 0, 10'd0, 8'd0, 1, 0, 8'h3C, 1);
        idle();

        // B write then read-back of the same address.
        step(0, 0, 10'd0, 8'd0, 1, 1, 10'd9, 8'hA5, 0, 1, 8'd0, 0);
        step(0, 0, 10'd0, 8'd0, 1, 0, 10'd9, 8'd0, 0, 1, 8'hA5, 1);
        idle();

        // Both requesting continuously: AAAA BBBB A.
        for (int i = 0; i < 9; i++) begin
            logic ga;
            ga = (i < 4) || (i == 8);
            step(1, 0, 10'd5, 8'd0, 1, 0, 10'd9, 8'd0, ga, !ga, ga ? 8'h3C : 8'hA5, 1);
        end
        idle();

        // A alone keeps the port past BURST; B arriving late is served at once.
        for (int i = 0; i < 10; i++) step(1, 0, 10'd5, 8'd0, 0, 0, 10'd0, 8'd0, 1, 0, 8'h3C, 1);
        step(1, 0, 10'd5, 8'd0, 1, 0, 10'd9, 8'd0, 0, 1, 8'hA5, 1);
        idle();

        // Idle gap after A: B wins the following tie.
        step(1, 0, 10'd9, 8'd0, 0, 0, 10'd0, 8'd0, 1, 0, 8'hA5, 1);
        repeat (3) idle();
        step(1, 0, 10'd5, 8'd0, 1, 0, 10'd9, 8'd0, 0, 1, 8'hA5, 1);
        idle();

        // Read accepted, then reset falls early in the next cycle: no rvalid, A priority after.
        step(1, 0, 10'd5, 8'd0, 0, 0, 10'd0, 8'd0, 1, 0, 8'd0, 0);
        #1 rstn = 1'b0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'd5; din_a = 8'h11;
        req_b = 1'b1; we_b = 1'b1; addr_b = 10'd9; din_b = 8'h22;
        #1;
        chk("mid-reset rvalid_a", 32'(rvalid_a), 32'd0);
        chk("mid-reset gnt_a", 32'(gnt_a), 32'd0);
        chk("mid-reset gnt_b", 32'(gnt_b), 32'd0);
        chk("mid-reset ram_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        step(1, 0, 10'd5, 8'd0, 1, 0, 10'd9, 8'd0, 1, 0, 8'h3C, 1);
        step(1, 0, 10'd5, 8'd0, 1, 0, 10'd9, 8'd0, 1, 0, 8'h3C, 1);
        repeat (4) idle();

        chk("qa drained", 32'(qa.size()), 32'd0);
        chk("qb drained", 32'(qb.size()), 32'd0);
        chk("mem[9]", 32'(mem[9]), 32'hA5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
